// File: rtl/grayscale_pkg.sv
// rtl/grayscale_pkg.sv - shared CSR map, control encodings, buffer/CCI-P types and FSM states for grayscale_ctrl
package grayscale_pkg;

  localparam logic [15:0] CSR_DSM_BASE = 16'h0044;
  localparam logic [15:0] CSR_CTRL     = 16'h0046;
  localparam logic [15:0] CSR_BUF_ADDR = 16'h0048;
  localparam logic [15:0] CSR_BUF_SIZE = 16'h004A;
  localparam logic [15:0] CSR_LIMIT    = 16'h0100;

  typedef logic [63:0] t_hc_address;
  typedef logic [63:0] t_hc_control;

  typedef struct packed {
    t_hc_address addr;
    logic [31:0] size;
  } t_hc_buffer;

  localparam t_hc_control CTRL_ASSERT_RST   = 64'h0;
  localparam t_hc_control CTRL_DEASSERT_RST = 64'h1;
  localparam t_hc_control CTRL_START        = 64'h3;
  localparam t_hc_control CTRL_STOP         = 64'h7;

  localparam logic [31:0] DSM_STATUS_COMPLETE = 32'd1;
  localparam logic [31:0] DSM_STATUS_ABORTED  = 32'd2;

  typedef enum logic [2:0] {
    S_RST      = 3'd0,
    S_IDLE     = 3'd1,
    S_RUN      = 3'd2,
    S_DSM_WR   = 3'd3,
    S_DSM_WAIT = 3'd4,
    S_DONE     = 3'd5
  } t_ctrl_state;

  typedef struct packed {
    logic [15:0] address;
    logic [1:0]  length;
    logic        rsvd;
    logic [8:0]  tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    logic [511:0]        data;
    logic                rspValid;
    logic                mmioRdValid;
    logic                mmioWrValid;
  } t_if_ccip_c0_Rx;

endpackage

// File: rtl/grayscale_csr_decode.sv
// rtl/grayscale_csr_decode.sv - registered capture of DSM base, buffer descriptors and control writes
module grayscale_csr_decode
  import grayscale_pkg::*;
#(
  parameter int N_BUFFERS = 2
) (
  input  logic                         clk,
  input  logic                         SoftReset,
  input  logic                         mmio_wr_valid,
  input  logic [15:0]                  mmio_addr,
  input  logic [63:0]                  mmio_data,
  input  logic                         busy,
  output t_hc_address                  dsm_base,
  output t_hc_buffer [N_BUFFERS-1:0]   buffers,
  output logic                         ctrl_valid,
  output t_hc_control                  ctrl_value
);

  t_hc_address                dsm_base_q, dsm_base_d;
  t_hc_buffer [N_BUFFERS-1:0] buffers_q, buffers_d;
  logic                       ctrl_valid_q, ctrl_valid_d;
  t_hc_control                ctrl_value_q, ctrl_value_d;
  logic                       accept;

  always_comb begin
    accept       = mmio_wr_valid && (mmio_addr < CSR_LIMIT);
    dsm_base_d   = dsm_base_q;
    buffers_d    = buffers_q;
    ctrl_valid_d = accept && (mmio_addr == CSR_CTRL);
    ctrl_value_d = mmio_data;
    // Descriptors are frozen while the engines may be reading them.
    if (accept && !busy) begin
      if (mmio_addr == CSR_DSM_BASE) dsm_base_d = mmio_data;
      for (int i = 0; i < N_BUFFERS; i++) begin
        if (mmio_addr == CSR_BUF_ADDR + 16'(4 * i)) buffers_d[i].addr = mmio_data;
        if (mmio_addr == CSR_BUF_SIZE + 16'(4 * i)) buffers_d[i].size = mmio_data[31:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (SoftReset) begin
      dsm_base_q   <= '0;
      buffers_q    <= '0;
      ctrl_valid_q <= 1'b0;
      ctrl_value_q <= '0;
    end else begin
      dsm_base_q   <= dsm_base_d;
      buffers_q    <= buffers_d;
      ctrl_valid_q <= ctrl_valid_d;
      ctrl_value_q <= ctrl_value_d;
    end
  end

  assign dsm_base   = dsm_base_q;
  assign buffers    = buffers_q;
  assign ctrl_valid = ctrl_valid_q;
  assign ctrl_value = ctrl_value_q;

endmodule

// File: rtl/grayscale_ctrl.sv
// rtl/grayscale_ctrl.sv - grayscale run sequencer and DSM completion writer
// Optional run-cycle counter in the DSM line: GRAYSCALE_CTRL_PERF_CNT_EN
module grayscale_ctrl
  import grayscale_pkg::*;
#(
  parameter int N_BUFFERS = 2
) (
  input  logic                        clk,
  input  logic                        SoftReset,
  input  t_if_ccip_c0_Rx              rx_mmio,
  input  logic                        c1TxAlmFull,
  input  logic                        c1_wr_rsp,
  input  logic                        rd_done,
  input  logic                        wr_done,
  output logic                        eng_rst,
  output logic                        eng_start,
  output logic [N_BUFFERS-1:0][63:0]  buf_addr,
  output logic [N_BUFFERS-1:0][31:0]  buf_size,
  output logic                        tx_c1_valid,
  output logic [41:0]                 tx_c1_addr,
  output logic [511:0]                tx_c1_data,
  output logic                        busy
);

  t_hc_address                dsm_base;
  t_hc_buffer [N_BUFFERS-1:0] buffers;
  logic                       ctrl_valid;
  t_hc_control                ctrl_value;

  t_ctrl_state state_q, state_d;
  logic        rd_seen_q, rd_seen_d;
  logic        wr_seen_q, wr_seen_d;
  logic [31:0] status_q, status_d;
  logic [31:0] perf_cnt;
  logic        is_start, is_stop, is_deassert, is_assert;

  grayscale_csr_decode #(.N_BUFFERS(N_BUFFERS)) u_csr (
    .clk           (clk),
    .SoftReset     (SoftReset),
    .mmio_wr_valid (rx_mmio.mmioWrValid),
    .mmio_addr     (rx_mmio.hdr.address),
    .mmio_data     (rx_mmio.data[63:0]),
    .busy          (busy),
    .dsm_base      (dsm_base),
    .buffers       (buffers),
    .ctrl_valid    (ctrl_valid),
    .ctrl_value    (ctrl_value)
  );

  always_comb begin
    is_start    = ctrl_valid && (ctrl_value == CTRL_START);
    is_stop     = ctrl_valid && (ctrl_value == CTRL_STOP);
    is_deassert = ctrl_valid && (ctrl_value == CTRL_DEASSERT_RST);
    is_assert   = ctrl_valid && (ctrl_value == CTRL_ASSERT_RST);
    state_d     = state_q;
    rd_seen_d   = rd_seen_q;
    wr_seen_d   = wr_seen_q;
    status_d    = status_q;
    eng_start   = 1'b0;
    tx_c1_valid = 1'b0;
    case (state_q)
      S_RST:      if (is_deassert) state_d = S_IDLE;
      S_IDLE, S_DONE: begin
        if (is_start) begin
          state_d   = S_RUN;
          eng_start = 1'b1;
          rd_seen_d = 1'b0;
          wr_seen_d = 1'b0;
        end
      end
      S_RUN: begin
        rd_seen_d = rd_seen_q | rd_done;
        wr_seen_d = wr_seen_q | wr_done;
        // STOP takes priority over a completion landing in the same cycle.
        if (is_stop) begin
          state_d  = S_DSM_WR;
          status_d = DSM_STATUS_ABORTED;
        end else if (rd_seen_d && wr_seen_d) begin
          state_d  = S_DSM_WR;
          status_d = DSM_STATUS_COMPLETE;
        end
      end
      S_DSM_WR: begin
        if (!c1TxAlmFull) begin
          tx_c1_valid = 1'b1;
          state_d     = S_DSM_WAIT;
        end
      end
      S_DSM_WAIT: if (c1_wr_rsp) state_d = S_DONE;
      default:    state_d = S_RST;
    endcase
    if (is_assert) state_d = S_RST;
  end

  always_ff @(posedge clk) begin
    if (SoftReset) begin
      state_q   <= S_RST;
      rd_seen_q <= 1'b0;
      wr_seen_q <= 1'b0;
      status_q  <= '0;
    end else begin
      state_q   <= state_d;
      rd_seen_q <= rd_seen_d;
      wr_seen_q <= wr_seen_d;
      status_q  <= status_d;
    end
  end

`ifdef GRAYSCALE_CTRL_PERF_CNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (eng_start) cnt_d = '0;
    else if (state_q == S_RUN && cnt_q != 32'hFFFF_FFFF) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (SoftReset) cnt_q <= '0;
    else           cnt_q <= cnt_d;
  end

  assign perf_cnt = cnt_q;
`else
  assign perf_cnt = '0;
`endif

  always_comb begin
    for (int i = 0; i < N_BUFFERS; i++) begin
      buf_addr[i] = buffers[i].addr;
      buf_size[i] = buffers[i].size;
    end
  end

  assign eng_rst    = (state_q == S_RST);
  assign busy       = (state_q == S_RUN) || (state_q == S_DSM_WR) || (state_q == S_DSM_WAIT);
  assign tx_c1_addr = dsm_base[47:6];
  assign tx_c1_data = {448'b0, perf_cnt, status_q};

  logic unused_ok;
  assign unused_ok = ^{rx_mmio.hdr.length, rx_mmio.hdr.rsvd, rx_mmio.hdr.tid, rx_mmio.data[511:64],
                       rx_mmio.rspValid, rx_mmio.mmioRdValid, dsm_base[63:48], dsm_base[5:0]};

endmodule
